incr_stream_checker: RTL and testbench

- Receive-side checker for the 8-bit counter stream produced by the single-state incrementing reactive device (output = state, state advances every cycle).
- Samples the device output and checks that each accepted sample equals the previous sample plus STEP, modulo 2^WIDTH.
- Acquires lock, then flags and counts sequence errors.
- Sits in regression benches and on-chip self-test between the device output and a status register.

---
 rtl/incr_stream_checker_if.sv | 24 ++
 rtl/incr_stream_checker.sv | 126 ++++++++++++
 tb/tb_incr_stream_checker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/incr_stream_checker_if.sv
// Bundles the sample stream, clear and status outputs of incr_stream_checker.
// The checker uses the slave modport; the stream source / status consumer uses master.
interface incr_stream_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             clear;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] last_value;

    modport master (
        output in_valid, in_data, clear,
        input  locked, err_pulse, err_count, last_value
    );

    modport slave (
        input  in_valid, in_data, clear,
        output locked, err_pulse, err_count, last_value
    );
endinterface

// File: rtl/incr_stream_checker.sv
// Receive-side checker for an incrementing counter stream: acquires lock after
// LOCK_COUNT consecutive +STEP samples, then flags and counts sequence errors.
module incr_stream_checker #(
    parameter int WIDTH      = 8,
    parameter int STEP       = 1,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    incr_stream_checker_if.slave  bus_if
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [8:0]       LOCK_TGT  = 9'(LOCK_COUNT);

    state_t           state_q,     state_d;
    logic [7:0]       match_q,     match_d;
    logic             locked_q,    locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [WIDTH-1:0] last_q,      last_d;

    logic [WIDTH-1:0] expected_s;
    logic             match_s;
    logic [8:0]       match_inc_s;

    // Modular expected value; wrap-around falls out of the WIDTH truncation.
    assign expected_s  = last_q + STEP_W;
    assign match_s     = (bus_if.in_data == expected_s);
    assign match_inc_s = {1'b0, match_q} + 9'd1;

    // Next-state, match-run and status computation.
    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        last_d      = last_q;

        if (bus_if.clear) begin
            // The concurrent sample is dropped; the reference value survives.
            state_d     = ST_HUNT;
            match_d     = 8'd0;
            locked_d    = 1'b0;
            err_count_d = {CNT_W{1'b0}};
        end else if (bus_if.in_valid) begin
            last_d = bus_if.in_data;
            case (state_q)
                ST_HUNT: begin
                    match_d  = 8'd0;
                    locked_d = 1'b0;
                    state_d  = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (match_s) begin
                        if (match_inc_s >= LOCK_TGT) begin
                            match_d  = LOCK_TGT[7:0];
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            match_d = match_inc_s[7:0];
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        locked_d = 1'b1;
                    end else begin
                        err_pulse_d = 1'b1;
                        locked_d    = 1'b0;
                        match_d     = 8'd0;
                        state_d     = ST_ACQUIRE;
                        if (err_count_q != CNT_MAX) begin
                            err_count_d = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            err_count_d = err_count_q;
                        end
                    end
                end
                default: begin
                    state_d  = ST_HUNT;
                    match_d  = 8'd0;
                    locked_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            match_q     <= 8'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= {CNT_W{1'b0}};
            last_q      <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            last_q      <= last_d;
        end
    end

    assign bus_if.locked     = locked_q;
    assign bus_if.err_pulse  = err_pulse_q;
    assign bus_if.err_count  = err_count_q;
    assign bus_if.last_value = last_q;

endmodule

// File: tb/tb_incr_stream_checker.sv
// Scoreboard bench for incr_stream_checker: two instances (default and CNT_W=2/LOCK_COUNT=1)
// checked each accepted edge against a rule-level reference model.
module tb_incr_stream_checker;

    logic clk;
    logic rst;

    incr_stream_checker_if #(.WIDTH(8), .CNT_W(16)) if0 ();
    incr_stream_checker_if #(.WIDTH(8), .CNT_W(2))  if1 ();

    incr_stream_checker #(.WIDTH(8), .STEP(1), .LOCK_COUNT(4), .CNT_W(16)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .bus_if (if0)
    );

    incr_stream_checker #(.WIDTH(8), .STEP(1), .LOCK_COUNT(1), .CNT_W(2)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .bus_if (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int locked;
        int pulse;
        int cnt;
        int last;
    } exp_t;

    exp_t expq[$];
    int n_cmp;
    int n_bad;

    // Reference model: 0 = hunting, 1 = acquiring, 2 = locked.
    int m_mode [2];
    int m_run  [2];
    int m_last [2];
    int m_cnt  [2];
    int m_pulse[2];
    int m_lc   [2] = '{4, 1};
    int m_cmax [2] = '{65535, 3};

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp = n_cmp + 1;
        if (act != expv) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_run[k] = 0; m_last[k] = 0; m_cnt[k] = 0; m_pulse[k] = 0;
        end
    endtask

    task automatic model_step(input int id, input logic v, input int d, input logic c);
        m_pulse[id] = 0;
        if (c) begin
            m_mode[id] = 0;
            m_run[id]  = 0;
            m_cnt[id]  = 0;
        end else if (v) begin
            if (m_mode[id] == 0) begin
                m_mode[id] = 1;
                m_run[id]  = 0;
            end else if (d == ((m_last[id] + 1) % 256)) begin
                if (m_mode[id] == 1) begin
                    m_run[id] = m_run[id] + 1;
                    if (m_run[id] >= m_lc[id]) m_mode[id] = 2;
                end
            end else begin
                if (m_mode[id] == 2) begin
                    m_pulse[id] = 1;
                    if (m_cnt[id] < m_cmax[id]) m_cnt[id] = m_cnt[id] + 1;
                end
                m_mode[id] = 1;
                m_run[id]  = 0;
            end
            m_last[id] = d;
        end
    endtask

    // One clock of stimulus on instance id; expectation queued after the edge.
    task automatic drive(input int id, input logic v, input int d, input logic c);
        exp_t e;
        if0.in_valid = 1'b0; if0.clear = 1'b0; if0.in_data = 8'h00;
        if1.in_valid = 1'b0; if1.clear = 1'b0; if1.in_data = 8'h00;
        if (id == 0) begin
            if0.in_valid = v; if0.in_data = d[7:0]; if0.clear = c;
        end else begin
            if1.in_valid = v; if1.in_data = d[7:0]; if1.clear = c;
        end
        model_step(id, v, d, c);
        e.id = id; e.locked = (m_mode[id] == 2) ? 1 : 0; e.pulse = m_pulse[id];
        e.cnt = m_cnt[id]; e.last = m_last[id];
        @(posedge clk);
        expq.push_back(e);
        #1;
    endtask

    task automatic feed(input int id, input int d);
        drive(id, 1'b1, d, 1'b0);
    endtask

    // Monitor: pops one expectation per DUT edge and compares on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.id == 0) begin
                chk("locked0",     int'(if0.locked),     e.locked);
                chk("err_pulse0",  int'(if0.err_pulse),  e.pulse);
                chk("err_count0",  int'(if0.err_count),  e.cnt);
                chk("last_value0", int'(if0.last_value), e.last);
            end else begin
                chk("locked1",     int'(if1.locked),     e.locked);
                chk("err_pulse1",  int'(if1.err_pulse),  e.pulse);
                chk("err_count1",  int'(if1.err_count),  e.cnt);
                chk("last_value1", int'(if1.last_value), e.last);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"},    int'(if0.locked),     0);
        chk({tag, "_err_pulse"}, int'(if0.err_pulse),  0);
        chk({tag, "_err_count"}, int'(if0.err_count),  0);
        chk({tag, "_last"},      int'(if0.last_value), 0);
    endtask

    task automatic random_run(input int id, input int n);
        int r;
        int d;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8) d = int'($urandom_range(0, 255));
            else       d = (m_last[id] + 1) % 256;
            drive(id, (r < 80), d, ($urandom_range(0, 63) == 0));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        if0.in_valid = 1'b0; if0.in_data = 8'h00; if0.clear = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = 8'h00; if1.clear = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        chk("reset_err_count1", int'(if1.err_count), 0);
        rst = 1'b0;

        // Lock acquisition
        for (int v = 8'h10; v <= 8'h14; v++) feed(0, v);
        // Wrap and gaps
        feed(0, 8'hFD); feed(0, 8'hFE);
        drive(0, 1'b0, 8'h55, 1'b0); drive(0, 1'b0, 8'hAA, 1'b0);
        feed(0, 8'hFF); feed(0, 8'h00); feed(0, 8'h01);
        // Error and relock
        feed(0, 8'h20);
        for (int v = 8'h21; v <= 8'h24; v++) feed(0, v);
        // Acquire mismatch stays silent (clear back to HUNT first)
        drive(0, 1'b1, 8'h77, 1'b1);
        feed(0, 8'h05); feed(0, 8'h06);
        for (int v = 8'h09; v <= 8'h0D; v++) feed(0, v);

        // Saturation and clear on the CNT_W=2, LOCK_COUNT=1 instance
        feed(1, 8'h00); feed(1, 8'h01);
        for (int k = 0; k < 5; k++) begin
            feed(1, (m_last[1] + 8'h40) % 256);
            feed(1, (m_last[1] + 1) % 256);
        end
        drive(1, 1'b1, (m_last[1] + 8'h40) % 256, 1'b1);
        feed(1, 8'h30); feed(1, 8'h31);
        random_run(1, 300);

        random_run(0, 600);

        // Build up two errors while locked, then reset between edges
        drive(0, 1'b1, 8'h00, 1'b1);
        feed(0, 8'h40);
        for (int v = 8'h41; v <= 8'h44; v++) feed(0, v);
        feed(0, 8'h50);
        for (int v = 8'h51; v <= 8'h54; v++) feed(0, v);
        feed(0, 8'h70);
        for (int v = 8'h71; v <= 8'h74; v++) feed(0, v);
        @(negedge clk);
        chk("pre_reset_locked", int'(if0.locked), 1);
        chk("pre_reset_count",  int'(if0.err_count), 2);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int v = 8'h01; v <= 8'h06; v++) feed(0, v);

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
